// File: rtl/wm_pkg.sv
// Shared types for the watermark message extractor.
// Holds the extractor FSM state enum and the default frame sync byte.
package wm_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2
  } wm_ext_state_t;

  localparam logic [7:0] WM_SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/wm_byte_fifo.sv
// Byte FIFO for recovered payload bytes.
// Ports: clk, reset (async high), clk_enable, push/din, pop/dout, full, empty.
module wm_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  logic w_pop;
  logic w_push;

  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);

  // A full FIFO still accepts a push when the head leaves this cycle.
  assign w_pop  = clk_enable & pop & ~empty;
  assign w_push = clk_enable & push & (~full | w_pop);

  assign dout = empty ? 8'h00 : r_mem[r_rd];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/wm_message_extractor.sv
// Recovers framed message bytes from one bit plane of watermarked pixels.
// Ports: clk, reset, clk_enable, pixel_in/valid in; msg_out/valid/ready, sync_locked, overflow.
module wm_message_extractor
  import wm_pkg::*;
#(
  parameter int         BIT_POS    = 0,
  parameter logic [7:0] SYNC_BYTE  = WM_SYNC_DEFAULT,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  output logic [7:0] msg_out,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic       sync_locked,
  output logic       overflow
);

  wm_ext_state_t r_state;
  logic [7:0]    r_win;
  logic [2:0]    r_cnt;
  logic [7:0]    r_n;
  logic          r_ovf;

  logic       w_accept;
  logic [7:0] w_win;
  logic       w_push;
  logic       w_full;
  logic       w_empty;
  logic       w_unused;

  assign w_unused = ^pixel_in;

  assign w_accept = clk_enable & pixel_valid;
  assign w_win    = {r_win[6:0], pixel_in[BIT_POS]};
  assign w_push   = w_accept & (r_state == PAYLOAD) & (r_cnt == 3'd7);

  assign msg_valid   = ~w_empty;
  assign sync_locked = (r_state != HUNT);
  assign overflow    = r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= HUNT;
      r_win   <= 8'h00;
      r_cnt   <= 3'd0;
      r_n     <= 8'h00;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_win <= w_win;
      unique case (r_state)
        HUNT: begin
          if (w_win == SYNC_BYTE) begin
            r_state <= LEN;
            r_win   <= 8'h00;
            r_cnt   <= 3'd0;
          end
        end
        LEN: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_n   <= w_win;
            r_win <= 8'h00;
            r_state <= (w_win == 8'h00) ? HUNT : PAYLOAD;
          end
        end
        PAYLOAD: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_n <= r_n - 8'd1;
            // Full and nothing leaving: byte is lost.
            if (w_full & ~msg_ready) r_ovf <= 1'b1;
            if (r_n == 8'd1) begin
              r_state <= HUNT;
              r_win   <= 8'h00;
            end
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  wm_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .push      (w_push),
    .din       (w_win),
    .pop       (msg_ready),
    .dout      (msg_out),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule

// File: doc/wm_message_extractor.md
WM_MESSAGE_EXTRACTOR -- requirements
Module: wm_message_extractor

Interface
REQ-001 SHALL have parameter BIT_POS, default 0: pixel bit index carrying the embedded message bit (0..7).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5: frame sync pattern.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output byte FIFO depth (power of 2, >=2).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clk_enable  input  1  global enable; when 0, all state and outputs hold.
REQ-007 pixel_in  input  8  watermarked pixel from the watermarker stage (its pixel_out).
REQ-008 pixel_valid  input  1  pixel_in carries a new sample this cycle.
REQ-009 msg_out  output  8  recovered payload byte (FIFO head).
REQ-010 msg_valid  output  1  msg_out is valid (FIFO not empty).
REQ-011 msg_ready  input  1  consumer accepts msg_out.
REQ-012 sync_locked  output  1  high while in LEN or PAYLOAD state.
REQ-013 overflow  output  1  sticky: a payload byte was dropped because the FIFO was full.

Function
REQ-014 A bit SHALL be accepted only on a cycle with clk_enable=1 and pixel_valid=1; the bit is pixel_in[BIT_POS].
REQ-015 Accepted bits SHALL shift MSB-first into an 8-bit window: window <= {window[6:0], bit}.
REQ-016 FSM states SHALL be HUNT, LEN, PAYLOAD.
REQ-017 HUNT: after each accepted bit, if the updated window equals SYNC_BYTE, go to LEN with the bit counter cleared; otherwise stay.
REQ-018 LEN: after 8 accepted bits, latch the byte as remaining-count N; N=0 -> HUNT; N>0 -> PAYLOAD.
REQ-019 PAYLOAD: every 8 accepted bits form one byte, pushed to the FIFO; N decrements; after the push making N=0, go to HUNT.
REQ-020 Sync and length bytes SHALL never be pushed to the FIFO.
REQ-021 A completed byte SHALL be written to the FIFO at the edge that accepts its 8th bit; msg_valid SHALL rise in the following cycle (1-cycle latency).
REQ-022 A pop SHALL occur on a cycle with clk_enable=1, msg_valid=1 and msg_ready=1; msg_out SHALL be stable while msg_valid=1 and msg_ready=0.
REQ-023 Push on a full FIFO with no simultaneous pop SHALL drop the byte, set overflow, and still decrement N.
REQ-024 Simultaneous push and pop on a full FIFO SHALL succeed with no overflow; on an empty FIFO, push only (no pop possible).
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-026 The window SHALL be cleared to 8'h00 on entering LEN and HUNT, so stale payload bits never form a false sync.
REQ-027 pixel_valid=1 with clk_enable=0 SHALL accept no bit.
REQ-028 overflow SHALL clear only by reset.

Reset
REQ-029 Reset assertion SHALL immediately force: state HUNT, window 8'h00, bit counter 0, N 0, FIFO empty, msg_out 8'h00, msg_valid 0, sync_locked 0, overflow 0.
REQ-030 Reset mid-frame SHALL discard the partial byte and all FIFO contents; hunting resumes on the first accepted bit after release.

Structure
REQ-031 Shared package wm_pkg SHALL hold the FSM state enum (wm_ext_state_t) and the default SYNC_BYTE constant.
REQ-032 The FIFO SHALL be a sub-module wm_byte_fifo (push/pop/full/empty, same clk/reset/clk_enable).

Verification
REQ-033 Frame A5, 03, 11, 22, 33 with msg_ready=1 -> msg_out 8'h11, 8'h22, 8'h33, each msg_valid one cycle after its 8th bit; sync_locked falls after 8'h33.
REQ-034 Noise 8'h5A, 8'hFF then frame A5, 01, C3 -> exactly one byte 8'hC3 output; no output from noise.
REQ-035 Frame A5, 00 -> no output; sync_locked high for 8 bit periods then low.
REQ-036 msg_ready=0, frame A5, 06, 01..06 with FIFO_DEPTH=4 -> FIFO holds 01..04, overflow=1; releasing ready yields 01..04 only.
REQ-037 Reset asserted after the 4th bit of payload byte 2 -> all outputs zero immediately; subsequent frame A5, 01, 7E yields 8'h7E.
REQ-038 Frame sent with clk_enable toggling 1-of-5 cycles and pixel_valid held high -> same bytes as REQ-033; no bit accepted while clk_enable=0.
